// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the
// multi-port integer register file.
package regfile_pkg;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write bus of the register file; the
// master drives requests, the slave returns data.
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);

  localparam int AW = $clog2(NREG);

  logic                re;
  logic [NRD*AW-1:0]   ra;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic [NRD*XLEN-1:0] rd;
  logic                rvalid;
  logic                init_busy;

  modport master (
    output re,
    output ra,
    output we,
    output wa,
    output wd,
    input  rd,
    input  rvalid,
    input  init_busy
  );

  modport slave (
    input  re,
    input  ra,
    input  we,
    input  wa,
    input  wd,
    output rd,
    output rvalid,
    output init_busy
  );

endinterface

// File: rtl/regfile_init_ctrl.sv
// Post-reset clearing FSM; owns the storage
// write port and shares it with normal writes.
module regfile_init_ctrl
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  output logic            init_busy,
  output logic            wen,
  output logic [AW-1:0]   waddr,
  output logic [XLEN-1:0] wdata
);

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] clr_q;
  logic [AW-1:0] clr_d;
  logic          wa_zero;

  assign wa_zero = (ZERO_REG != 0) && (wa == '0);

  // State and clear pointer; reset restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // Next state and write-port mux; nothing lands while rst is high.
  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    init_busy = 1'b0;
    wen       = 1'b0;
    waddr     = wa;
    wdata     = wd;
    unique case (state_q)
      INIT: begin
        init_busy = 1'b1;
        wen       = ~rst;
        waddr     = clr_q;
        wdata     = '0;
        clr_d     = clr_q + AW'(1);
        if (clr_q == AW'(NREG - 1))
          state_d = READY;
      end
      READY: begin
        wen = we & ~rst & ~wa_zero;
      end
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NRD registered read
// ports with write-first bypass, cleared after reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0]     mem [NREG];
  logic                wen;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                busy;
  logic                rd_en;
  logic [NRD*XLEN-1:0] cap;
  logic [NRD*XLEN-1:0] rd_q;
  logic                rv_q;

  regfile_init_ctrl #(
    .XLEN     (XLEN),
    .NREG     (NREG),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .we        (bus.we),
    .wa        (bus.wa),
    .wd        (bus.wd),
    .init_busy (busy),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  assign rd_en = bus.re & ~busy;

  // Single write port; no reset so the array maps to RAM.
  always_ff @(posedge clk) begin
    if (wen)
      mem[waddr] <= wdata;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    logic          zero;
    assign a    = bus.ra[g*AW +: AW];
    assign hit  = bus.we & (bus.wa == a);
    assign zero = (ZERO_REG != 0) && (a == '0);
    assign cap[g*XLEN +: XLEN] =
      zero ? '0 :
      hit  ? bus.wd :
             mem[a];
  end

  // Read data/valid registers; rd holds when no read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      rv_q <= rd_en;
      if (rd_en)
        rd_q <= cap;
    end
  end

  assign bus.rd        = rd_q;
  assign bus.rvalid    = rv_q;
  assign bus.init_busy = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default,
// ZERO_REG=0 and 64x16x3 builds side by side.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) b0 ();
  regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) b1 ();
  regfile_mp_if #(.XLEN(64), .NREG(16), .NRD(3)) b2 ();

  regfile_mp #(.ZERO_REG(1)) dut0 (
    .clk (clk), .rst (rst), .bus (b0.slave)
  );
  regfile_mp #(.ZERO_REG(0)) dut1 (
    .clk (clk), .rst (rst), .bus (b1.slave)
  );
  regfile_mp #(
    .XLEN(64), .NREG(16), .NRD(3), .ZERO_REG(1)
  ) dut2 (
    .clk (clk), .rst (rst), .bus (b2.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m [32];
  logic [31:0] e_rd [2];
  bit          e_rv;

  typedef struct {
    bit        re;
    bit [4:0]  r0;
    bit [4:0]  r1;
    bit        we;
    bit [4:0]  wa;
    bit [31:0] wd;
    bit        erv;
    bit [31:0] e0;
    bit [31:0] e1;
  } vec_t;

  vec_t tv [9];

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < 32; i++) m[i] = '0;
    e_rd[0] = '0;
    e_rd[1] = '0;
    e_rv    = 1'b0;
  endtask

  function automatic logic [31:0] ref_rd(
    bit [4:0] a, bit we, bit [4:0] wa, bit [31:0] wd);
    if (a == 0) return '0;
    if (we && wa == a) return wd;
    return m[a];
  endfunction

  // Drive one READY-mode request on dut0 and
  // advance the reference model by one cycle.
  task automatic drive0(bit re, bit [4:0] r0,
                        bit [4:0] r1, bit we,
                        bit [4:0] wa, bit [31:0] wd);
    b0.re = re;
    b0.ra = {r1, r0};
    b0.we = we;
    b0.wa = wa;
    b0.wd = wd;
    e_rv  = re;
    if (re) begin
      e_rd[0] = ref_rd(r0, we, wa, wd);
      e_rd[1] = ref_rd(r1, we, wa, wd);
    end
    if (we && wa != 0) m[wa] = wd;
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Count busy cycles on all three builds while
  // dut0 is hammered with reads/writes to reg 20.
  task automatic count_init(string nm);
    int c0 = 0;
    int c1 = 0;
    int c2 = 0;
    int k  = 0;
    b0.re = 1'b1;
    b0.ra = {5'd20, 5'd20};
    b0.we = 1'b1;
    b0.wa = 5'd20;
    b0.wd = $urandom;
    while ((b0.init_busy || b1.init_busy ||
            b2.init_busy) && k < 200) begin
      c0 += int'(b0.init_busy);
      c1 += int'(b1.init_busy);
      c2 += int'(b2.init_busy);
      if (b0.init_busy)
        chk({nm, "_rvalid"}, 64'(b0.rvalid), 0);
      tick();
      k++;
    end
    chk({nm, "_busy0"}, 64'(c0), 32);
    chk({nm, "_busy1"}, 64'(c1), 32);
    chk({nm, "_busy2"}, 64'(c2), 16);
    model_clear();
  endtask

  initial begin
    b0.re = 0; b0.ra = '0; b0.we = 0;
    b0.wa = '0; b0.wd = '0;
    b1.re = 0; b1.ra = '0; b1.we = 0;
    b1.wa = '0; b1.wd = '0;
    b2.re = 0; b2.ra = '0; b2.we = 0;
    b2.wa = '0; b2.wd = '0;
    model_clear();

    tv[0] = '{0, 0, 0, 1, 5, 32'hDEADBEEF,
              0, 0, 0};
    tv[1] = '{1, 5, 5, 0, 0, 0,
              1, 32'hDEADBEEF, 32'hDEADBEEF};
    tv[2] = '{0, 0, 0, 1, 7, 32'h11,
              0, 32'hDEADBEEF, 32'hDEADBEEF};
    tv[3] = '{0, 0, 0, 1, 3, 32'h33,
              0, 32'hDEADBEEF, 32'hDEADBEEF};
    tv[4] = '{1, 7, 3, 1, 7, 32'h22,
              1, 32'h22, 32'h33};
    tv[5] = '{1, 7, 7, 0, 0, 0,
              1, 32'h22, 32'h22};
    tv[6] = '{1, 0, 0, 1, 0, 32'hFFFFFFFF,
              1, 0, 0};
    tv[7] = '{1, 0, 5, 0, 0, 0,
              1, 0, 32'hDEADBEEF};
    tv[8] = '{0, 0, 0, 0, 0, 0,
              0, 0, 32'hDEADBEEF};

    tick();
    chk("rst_busy", 64'(b0.init_busy), 1);
    chk("rst_rvalid", 64'(b0.rvalid), 0);
    chk("rst_rd", 64'(b0.rd), 0);
    tick();
    rst = 1'b0;
    count_init("init0");

    for (int i = 0; i < 9; i++) begin
      drive0(tv[i].re, tv[i].r0, tv[i].r1,
             tv[i].we, tv[i].wa, tv[i].wd);
      tick();
      chk($sformatf("vec%0d_rvalid", i),
          64'(b0.rvalid), 64'(tv[i].erv));
      chk($sformatf("vec%0d_rd0", i),
          64'(b0.rd[31:0]), 64'(tv[i].e0));
      chk($sformatf("vec%0d_rd1", i),
          64'(b0.rd[63:32]), 64'(tv[i].e1));
    end

    b1.we = 1; b1.wa = 0; b1.wd = 32'hFFFFFFFF;
    b1.re = 1; b1.ra = '0;
    tick();
    b1.we = 0;
    chk("z0_byp_rd0", 64'(b1.rd[31:0]),
        64'hFFFFFFFF);
    chk("z0_byp_rd1", 64'(b1.rd[63:32]),
        64'hFFFFFFFF);
    tick();
    b1.re = 0;
    chk("z0_read_rd0", 64'(b1.rd[31:0]),
        64'hFFFFFFFF);

    b2.we = 1; b2.wa = 4'd15;
    b2.wd = 64'h0123456789ABCDEF;
    tick();
    b2.we = 0; b2.re = 1;
    b2.ra = {4'd1, 4'd15, 4'd15};
    tick();
    b2.re = 0;
    chk("p64_rvalid", 64'(b2.rvalid), 1);
    chk("p64_rd0", b2.rd[63:0],
        64'h0123456789ABCDEF);
    chk("p64_rd1", b2.rd[127:64],
        64'h0123456789ABCDEF);
    chk("p64_rd2", b2.rd[191:128], 0);

    for (int i = 0; i < 400; i++) begin
      bit [4:0] wa = 5'($urandom_range(0, 31));
      bit [4:0] r0 = ($urandom_range(0, 3) == 0) ?
                     wa : 5'($urandom_range(0, 31));
      bit [4:0] r1 = ($urandom_range(0, 3) == 0) ?
                     wa : 5'($urandom_range(0, 31));
      drive0(1'($urandom), r0, r1,
             1'($urandom), wa, $urandom);
      tick();
      chk("rnd_rvalid", 64'(b0.rvalid), 64'(e_rv));
      chk("rnd_rd0", 64'(b0.rd[31:0]),
          64'(e_rd[0]));
      chk("rnd_rd1", 64'(b0.rd[63:32]),
          64'(e_rd[1]));
    end

    pulse_rst();
    chk("rst2_rd", 64'(b0.rd), 0);
    chk("rst2_rvalid", 64'(b0.rvalid), 0);
    count_init("init1");
    for (int k = 0; k < 16; k++) begin
      drive0(1, 5'(2*k), 5'(2*k+1), 0, 0, 0);
      tick();
      chk($sformatf("clr_rd%0d", 2*k),
          64'(b0.rd[31:0]), 64'(e_rd[0]));
      chk($sformatf("clr_rd%0d", 2*k+1),
          64'(b0.rd[63:32]), 64'(e_rd[1]));
    end

    for (int i = 1; i < 32; i++) begin
      drive0(0, 0, 0, 1, 5'(i), $urandom | 1);
      tick();
    end
    pulse_rst();
    b0.re = 1; b0.we = 1; b0.wa = 5'd20;
    b0.ra = {5'd20, 5'd20};
    for (int k = 0; k < 10; k++) begin
      chk("mid_rvalid", 64'(b0.rvalid), 0);
      tick();
    end
    pulse_rst();
    count_init("init2");
    for (int k = 0; k < 16; k++) begin
      drive0(1, 5'(2*k), 5'(2*k+1), 0, 0, 0);
      tick();
      chk($sformatf("mid_rd%0d", 2*k),
          64'(b0.rd[31:0]), 64'(e_rd[0]));
      chk($sformatf("mid_rd%0d", 2*k+1),
          64'(b0.rd[63:32]), 64'(e_rd[1]));
    end
    chk("mid_rvalid_end", 64'(b0.rvalid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
